// File: rtl/pipe_skid_buffer_pkg.sv
// Shared definitions for the two-entry pipeline skid buffer.
// The state encoding doubles as the stored-entry count.
package pipe_skid_buffer_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_BUSY  = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_e;

endpackage

// File: rtl/skid_data_reg.sv
// Payload register with load enable and asynchronous active-low clear to zero.
module skid_data_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) data_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic buffer with registered ready; main register is always the head,
// skid register holds the second entry while the consumer stalls.
module pipe_skid_buffer
  import pipe_skid_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  skid_state_e      state_q;
  skid_state_e      state_d;
  logic             main_load;
  logic             skid_load;
  logic [WIDTH-1:0] main_src;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             wr_fire;
  logic             rd_fire;

  assign out_valid = (state_q != SKID_EMPTY);
  assign in_ready  = (state_q != SKID_FULL);
  assign count     = state_q;
  assign out_data  = main_q;

  assign wr_fire = in_valid & in_ready;
  assign rd_fire = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_src  = in_data;
    case (state_q)
      SKID_EMPTY: begin
        if (wr_fire) begin
          state_d   = SKID_BUSY;
          main_load = 1'b1;
        end
      end
      SKID_BUSY: begin
        if (wr_fire && rd_fire) begin
          main_load = 1'b1;
        end else if (wr_fire) begin
          state_d   = SKID_FULL;
          skid_load = 1'b1;
        end else if (rd_fire) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (rd_fire) begin
          state_d   = SKID_BUSY;
          main_load = 1'b1;
          main_src  = skid_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    // Flush discards everything, including a write offered this cycle.
    if (flush) begin
      state_d   = SKID_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= SKID_EMPTY;
    else      state_q <= state_d;
  end

  skid_data_reg #(.WIDTH(WIDTH)) u_main_reg (
    .clk   (clk),
    .rst_n (rst),
    .load  (main_load),
    .d     (main_src),
    .q     (main_q)
  );

  skid_data_reg #(.WIDTH(WIDTH)) u_skid_reg (
    .clk   (clk),
    .rst_n (rst),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer: queue model compared every cycle,
// plus directed vectors with literal expectations.
module tb_pipe_skid_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] mq[$];
  logic [31:0] last_read;
  int unsigned reads_seen = 0;
  logic        seen_44_55 = 1'b0;

  pipe_skid_buffer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of depth two, cleared by reset or flush.
  always @(posedge clk or negedge rst) begin
    bit rd, wr;
    if (!rst) begin
      mq.delete();
    end else begin
      rd = (mq.size() > 0) && out_ready;
      wr = in_valid && (mq.size() < 2);
      if (rd) begin
        last_read = mq.pop_front();
        reads_seen++;
      end
      if (flush) mq.delete();
      else if (wr) mq.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("m_out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
      check("m_in_ready",  {31'b0, in_ready},  {31'b0, mq.size() < 2});
      check("m_count",     {30'b0, count},     mq.size());
      if (mq.size() != 0) check("m_out_data", out_data, mq[0]);
      if (out_valid && (out_data == 32'h44 || out_data == 32'h55)) seen_44_55 = 1'b1;
    end
  end

  // Drive at a negedge, return at the next negedge (one rising edge in between).
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  initial begin
    int unsigned r0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    check("rst_count",     {30'b0, count},     32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_data",  out_data,           32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Stall fill
    step(1, 32'hAA, 0, 0);
    check("fill1_count", {30'b0, count}, 32'd1);
    check("fill1_data",  out_data,       32'hAA);
    step(1, 32'hBB, 0, 0);
    check("fill2_count",    {30'b0, count},    32'd2);
    check("fill2_in_ready", {31'b0, in_ready}, 32'd0);
    check("fill2_data",     out_data,          32'hAA);
    step(1, 32'hCC, 0, 0);
    check("cc_rejected_count", {30'b0, count}, 32'd2);
    check("cc_rejected_data",  out_data,       32'hAA);

    // Asynchronous reset mid-cycle with two entries stored
    #3 rst = 1'b0;
    #1;
    check("arst_count",     {30'b0, count},     32'd0);
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_in_ready",  {31'b0, in_ready},  32'd1);
    check("arst_out_data",  out_data,           32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 32'hA5A5_0001, 1, 0);
    check("post_rst_valid", {31'b0, out_valid}, 32'd1);
    check("post_rst_data",  out_data,           32'hA5A5_0001);
    step(0, 32'h0, 1, 0);
    check("post_rst_drain", {30'b0, count}, 32'd0);

    // Stall recovery: AA, BB stored; CC offered while draining
    step(1, 32'hAA, 0, 0);
    step(1, 32'hBB, 0, 0);
    step(1, 32'hCC, 1, 0);
    check("rec1_data",     out_data,          32'hBB);
    check("rec1_count",    {30'b0, count},    32'd1);
    check("rec1_in_ready", {31'b0, in_ready}, 32'd1);
    check("rec1_read",     last_read,         32'hAA);
    step(1, 32'hCC, 1, 0);
    check("rec2_data", out_data,  32'hCC);
    check("rec2_read", last_read, 32'hBB);
    step(0, 32'h0, 1, 0);
    check("rec3_read",  last_read,      32'hCC);
    check("rec3_count", {30'b0, count}, 32'd0);

    // Streaming 0x1..0x10
    r0 = reads_seen;
    for (int unsigned i = 1; i <= 16; i++) begin
      step(1, i, 1, 0);
      check("stream_count", {30'b0, count}, 32'd1);
      check("stream_data",  out_data,       i);
    end
    step(0, 32'h0, 1, 0);
    check("stream_reads", reads_seen - r0, 32'd16);
    check("stream_last",  last_read,       32'h10);

    // Simultaneous write and read in BUSY
    step(1, 32'h11, 0, 0);
    step(1, 32'h22, 1, 0);
    check("sim_data",  out_data,       32'h22);
    check("sim_count", {30'b0, count}, 32'd1);
    check("sim_read",  last_read,      32'h11);
    step(0, 32'h0, 1, 0);

    // Flush in FULL with a concurrent read and write
    step(1, 32'h33, 0, 0);
    step(1, 32'h44, 0, 0);
    seen_44_55 = 1'b0;
    check("pre_flush_data", out_data, 32'h33);
    r0 = reads_seen;
    step(1, 32'h55, 1, 1);
    check("flush_count",     {30'b0, count},     32'd0);
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_read",      last_read,          32'h33);
    check("flush_reads",     reads_seen - r0,    32'd1);
    step(1, 32'h66, 1, 0);
    check("after_flush_data", out_data, 32'h66);
    step(0, 32'h0, 1, 0);
    check("no_44_55", {31'b0, seen_44_55}, 32'd0);

    // Randomised handshakes against the model
    for (int unsigned c = 0; c < 10000; c++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 63) == 0));
    end
    step(0, 32'h0, 1, 0);
    step(0, 32'h0, 1, 0);
    check("final_count", {30'b0, count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_buffer.md
# pipe_skid_buffer

Two-entry elastic buffer between adjacent pipeline stages, with a valid/ready handshake on both sides. The upstream stage writes into it and the downstream stage reads from it. `in_ready` is driven purely from state, which breaks the combinational ready path between stages while sustaining one transfer per cycle. It sits on stage boundaries (e.g. fetch→decode) and supports a synchronous flush for branch redirects.

## Interface
- `WIDTH`, default 32, payload width in bits.

- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous discard of all stored entries.
- `in_valid` input 1: upstream offers `in_data`.
- `in_ready` output 1: buffer accepts a write this cycle.
- `in_data` input WIDTH: write payload.
- `out_valid` output 1: `out_data` holds a valid entry.
- `out_ready` input 1: downstream consumes this cycle.
- `out_data` output WIDTH: read payload, always the oldest entry.
- `count` output 2: stored entries (0, 1 or 2).

## Operation
- Storage:
  - main register: head, drives `out_data`.
  - skid register: second entry.
- Write fire: `in_valid & in_ready`.
- Read fire: `out_valid & out_ready`.
- States:
  - EMPTY: count 0.
  - BUSY: main valid, count 1.
  - FULL: main and skid valid, count 2.
- Outputs from state only:
  - `out_valid` = (state != EMPTY).
  - `in_ready` = (state != FULL).
  - `count` = state count.
- Transitions, with `flush` low:
  - EMPTY + write → BUSY; main ← `in_data`.
  - BUSY + write + read → BUSY; main ← `in_data`.
  - BUSY + write, no read → FULL; skid ← `in_data`.
  - BUSY + read, no write → EMPTY.
  - FULL + read → BUSY; main ← skid. No write is possible because `in_ready` = 0.
  - No fire → hold state and data.
- `flush` high overrides all transitions: next state EMPTY.
  - A read fire in the same cycle still counts as delivered to the consumer.
  - A write offered in the same cycle is dropped. `in_ready` may be 1, and upstream must treat the flush as cancelling its transfer.
- Ordering: strict FIFO. No entry is duplicated or lost except by `flush`.
- `in_data` and `out_ready` are ignored when the corresponding valid is low.
- Data registers load only on the listed transitions and otherwise hold their value.

## Timing
- Reset (`rst` low, asynchronous) sets:
  - state EMPTY, `out_valid` = 0, `in_ready` = 1, `count` = 0.
  - main and skid = 0, so `out_data` = 0.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency: a write in cycle N appears on `out_data` with `out_valid` = 1 in cycle N+1, provided the buffer was EMPTY, or BUSY with a read in cycle N.
- Throughput: 1 transfer per cycle sustained while `out_ready` = 1.
- No combinational path from any input to any output, except that `out_data` follows main register contents only.
- Stall recovery: after FULL, the first read returns main, and the skid entry becomes head in the next cycle. `in_ready` rises in the cycle after that read.

## Structure
- Put the state encoding in the shared `defines.v`:
  - `SKID_EMPTY` = 2'b00
  - `SKID_BUSY` = 2'b01
  - `SKID_FULL` = 2'b10
- The encoding value equals `count`.
- One sub-module, `skid_data_reg`: a WIDTH-bit register with load enable, asynchronous active-low reset to 0. Instantiate it twice, for main and skid.
- Keep the FSM and load/mux control in `pipe_skid_buffer` itself.

## Test plan
- Reset: hold `rst` low mid-stream with count = 2 → `count` = 0, `out_valid` = 0, `in_ready` = 1, `out_data` = 0 asynchronously. After release, the first write 0xA5A5_0001 appears one cycle later.
- Streaming: `out_ready` = 1, write 0x1..0x10 back-to-back → 16 reads in order 0x1..0x10, one per cycle, `count` stays 1.
- Stall fill: `out_ready` = 0, write 0xAA then 0xBB → `count` = 2, `in_ready` = 0, `out_data` = 0xAA. A further offered 0xCC is not accepted. Raise `out_ready` → reads 0xAA, 0xBB, then 0xCC after it is accepted.
- Simultaneous events in BUSY: holding 0x11, write 0x22 with `out_ready` = 1 → 0x11 read, head becomes 0x22, `count` stays 1.
- Flush: in FULL (0x33, 0x44), assert `flush` with `out_ready` = 1 and `in_valid` = 1 (0x55) → 0x33 counted as read. Next cycle `count` = 0, `out_valid` = 0. Neither 0x44 nor 0x55 is ever output.
- Randomized `in_valid`/`out_ready` for 10k cycles against a queue model → no loss, no duplication, order preserved, and `count` always equals the model depth.
